// File: rtl/tlb_pkg.sv
// Shared encodings for the L1 TLB: FSM states, access codes, PTE flag bit positions.
package tlb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_WALK   = 2'd2
    } tlb_state_e;

    localparam logic [1:0] ACC_LOAD  = 2'b00;
    localparam logic [1:0] ACC_STORE = 2'b01;
    localparam logic [1:0] ACC_FETCH = 2'b10;
    localparam logic [1:0] ACC_RSVD  = 2'b11;

    localparam int FLAG_R = 0;
    localparam int FLAG_W = 1;
    localparam int FLAG_X = 2;
    localparam int FLAG_U = 3;

    // Reserved access code never grants permission.
    function automatic logic perm_ok(input logic [3:0] flags, input logic [1:0] access,
                                     input logic user);
        logic need;
        case (access)
            ACC_LOAD:  need = flags[FLAG_R];
            ACC_STORE: need = flags[FLAG_W];
            ACC_FETCH: need = flags[FLAG_X];
            default:   need = 1'b0;
        endcase
        return need && (flags[FLAG_U] == user);
    endfunction

endpackage

// File: rtl/tlb_victim_sel.sv
// Replacement choice: lowest-index invalid entry, otherwise a round-robin pointer
// that advances only when it is actually used for an allocation.
module tlb_victim_sel #(
    parameter int ENTRIES = 8,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ENTRIES-1:0] valid_vec,
    input  logic               alloc,
    output logic [IDX_W-1:0]   victim_idx
);

    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] free_idx;
    logic             free_found;

    always_comb begin
        free_idx   = '0;
        free_found = 1'b0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!valid_vec[i]) begin
                free_idx   = IDX_W'(i);
                free_found = 1'b1;
            end
        end
    end

    assign victim_idx = free_found ? free_idx : rr_ptr;

    // ENTRIES is a power of two, so the pointer wraps naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (alloc && !free_found) begin
            rr_ptr <= rr_ptr + IDX_W'(1);
        end
    end

endmodule

// File: rtl/l1_tlb.sv
// Fully-associative L1 TLB: registered response 2 cycles after accept on a hit,
// one cycle after walker completion on a miss; one request in flight, flush wins over request.
module l1_tlb
    import tlb_pkg::*;
#(
    parameter int ENTRIES    = 8,
    parameter int VPN_WIDTH  = 20,
    parameter int PPN_WIDTH  = 20,
    parameter int ASID_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [VPN_WIDTH-1:0]  req_vpn,
    input  logic [ASID_WIDTH-1:0] req_asid,
    input  logic [1:0]            req_access,
    input  logic                  req_user,
    output logic                  resp_valid,
    output logic [PPN_WIDTH-1:0]  resp_ppn,
    output logic                  resp_fault,
    output logic                  resp_hit,
    output logic                  ptw_request,
    output logic [VPN_WIDTH-1:0]  ptw_vpn,
    output logic [ASID_WIDTH-1:0] ptw_asid,
    input  logic                  ptw_done,
    input  logic                  ptw_fault,
    input  logic [PPN_WIDTH-1:0]  ptw_result_ppn,
    input  logic [3:0]            ptw_result_flags,
    input  logic                  ptw_result_global,
    input  logic                  flush_valid,
    output logic                  flush_ready,
    input  logic                  flush_asid_en,
    input  logic [ASID_WIDTH-1:0] flush_asid,
    output logic [1:0]            tlb_state
);

    localparam int IDX_W = $clog2(ENTRIES);

    tlb_state_e state, state_nxt;

    logic [VPN_WIDTH-1:0]  q_vpn;
    logic [ASID_WIDTH-1:0] q_asid;
    logic [1:0]            q_access;
    logic                  q_user;

    logic [ENTRIES-1:0]    ent_vld;
    logic [ENTRIES-1:0]    ent_g;
    logic [VPN_WIDTH-1:0]  ent_vpn   [ENTRIES];
    logic [ASID_WIDTH-1:0] ent_asid  [ENTRIES];
    logic [PPN_WIDTH-1:0]  ent_ppn   [ENTRIES];
    logic [3:0]            ent_flags [ENTRIES];

    logic             hit;
    logic [IDX_W-1:0] hit_idx;
    logic [IDX_W-1:0] victim_idx;
    logic             fill;
    logic             flush_acc;
    logic             req_acc;

    assign req_ready   = (state == ST_IDLE) && !flush_valid;
    assign flush_ready = (state == ST_IDLE);
    assign ptw_request = (state == ST_WALK);
    assign ptw_vpn     = q_vpn;
    assign ptw_asid    = q_asid;
    assign tlb_state   = state;
    assign req_acc     = req_valid && req_ready;
    assign flush_acc   = flush_valid && flush_ready;
    // A simultaneous done+fault is a fault, so nothing is written.
    assign fill        = (state == ST_WALK) && ptw_done && !ptw_fault;

    // Descending scan so the lowest matching index is the one left standing.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (ent_vld[i] && ent_vpn[i] == q_vpn && (ent_g[i] || ent_asid[i] == q_asid)) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        state_nxt = ST_IDLE;
        case (state)
            ST_IDLE:   state_nxt = req_acc ? ST_LOOKUP : ST_IDLE;
            ST_LOOKUP: state_nxt = hit ? ST_IDLE : ST_WALK;
            ST_WALK:   state_nxt = (ptw_done || ptw_fault) ? ST_IDLE : ST_WALK;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (req_acc) begin
            q_vpn    <= req_vpn;
            q_asid   <= req_asid;
            q_access <= req_access;
            q_user   <= req_user;
        end
    end

    tlb_victim_sel #(.ENTRIES(ENTRIES), .IDX_W(IDX_W)) u_victim (
        .clk        (clk),
        .rst        (rst),
        .valid_vec  (ent_vld),
        .alloc      (fill),
        .victim_idx (victim_idx)
    );

    // Flush is only accepted in IDLE and fills only happen in WALK, so they never collide.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ent_vld <= '0;
        end else if (flush_acc) begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (!flush_asid_en || (!ent_g[i] && ent_asid[i] == flush_asid)) begin
                    ent_vld[i] <= 1'b0;
                end
            end
        end else if (fill) begin
            ent_vld[victim_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (fill) begin
            ent_vpn[victim_idx]   <= q_vpn;
            ent_asid[victim_idx]  <= q_asid;
            ent_ppn[victim_idx]   <= ptw_result_ppn;
            ent_flags[victim_idx] <= ptw_result_flags;
            ent_g[victim_idx]     <= ptw_result_global;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_valid <= 1'b0;
            resp_hit   <= 1'b0;
            resp_fault <= 1'b0;
            resp_ppn   <= '0;
        end else begin
            resp_valid <= 1'b0;
            resp_hit   <= 1'b0;
            resp_fault <= 1'b0;
            resp_ppn   <= '0;
            if (state == ST_LOOKUP && hit) begin
                resp_valid <= 1'b1;
                resp_hit   <= 1'b1;
                if (perm_ok(ent_flags[hit_idx], q_access, q_user)) begin
                    resp_ppn <= ent_ppn[hit_idx];
                end else begin
                    resp_fault <= 1'b1;
                end
            end else if (state == ST_WALK && ptw_fault) begin
                resp_valid <= 1'b1;
                resp_fault <= 1'b1;
            end else if (fill) begin
                resp_valid <= 1'b1;
                if (perm_ok(ptw_result_flags, q_access, q_user)) begin
                    resp_ppn <= ptw_result_ppn;
                end else begin
                    resp_fault <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/l1_tlb.md
L1_TLB -- requirements
Module: l1_tlb

Interface
REQ-001 SHALL have parameter ENTRIES, default 8: number of fully-associative entries (power of 2, 2..32).
REQ-002 SHALL have parameter VPN_WIDTH, default 20: virtual page number width.
REQ-003 SHALL have parameter PPN_WIDTH, default 20: physical page number width.
REQ-004 SHALL have parameter ASID_WIDTH, default 8: address-space ID width.
REQ-005 SHALL have ports, clock and reset first:
clk  in  1  sole clock, rising edge
rst  in  1  asynchronous, active-high reset
req_valid  in  1  translation request
req_ready  out  1  request accepted when req_valid&&req_ready
req_vpn  in  VPN_WIDTH  virtual page number
req_asid  in  ASID_WIDTH  current ASID
req_access  in  2  00 load, 01 store, 10 fetch, 11 reserved (treated as fault)
req_user  in  1  1 = user-mode access
resp_valid  out  1  one-cycle response pulse
resp_ppn  out  PPN_WIDTH  translated PPN (0 when resp_fault)
resp_fault  out  1  page/permission fault
resp_hit  out  1  1 = served from TLB, 0 = served after walk
ptw_request  out  1  walk request to page table walker
ptw_vpn  out  VPN_WIDTH  latched request VPN
ptw_asid  out  ASID_WIDTH  latched request ASID
ptw_done  in  1  walk complete, results valid this cycle
ptw_fault  in  1  walk failed
ptw_result_ppn  in  PPN_WIDTH  walked PPN
ptw_result_flags  in  4  {U,X,W,R}
ptw_result_global  in  1  G bit
flush_valid  in  1  invalidate request (sfence.vma)
flush_ready  out  1  flush accepted when flush_valid&&flush_ready
flush_asid_en  in  1  0 = flush all, 1 = flush non-global entries of flush_asid
flush_asid  in  ASID_WIDTH  ASID to flush
tlb_state  out  2  FSM state, debug

Function
REQ-006 SHALL implement FSM IDLE(0), LOOKUP(1), WALK(2); encoding 3 unused, recovers to IDLE.
REQ-007 req_ready SHALL be 1 only in IDLE with flush_valid=0; flush_ready SHALL be 1 only in IDLE.
REQ-008 On accept, SHALL latch vpn/asid/access/user and go to LOOKUP.
REQ-009 Hit in LOOKUP: entry valid && vpn equal && (G || asid equal); multiple hits resolve to lowest index.
REQ-010 On hit: registered resp_valid=1, resp_hit=1 next cycle (accept-to-response 2 cycles), state to IDLE.
REQ-011 On miss: state to WALK; ptw_request SHALL equal (state==WALK), held high until cycle ptw_done or ptw_fault is seen.
REQ-012 In WALK, ptw_done SHALL write the entry and register resp_valid=1, resp_hit=0 for the next cycle, state to IDLE; ptw_fault SHALL register resp_fault=1, resp_ppn=0, write nothing; ptw_done and ptw_fault together SHALL be treated as fault.
REQ-013 Permission: load needs R, store needs W, fetch needs X; user access needs U=1, supervisor access needs U=0; a violation sets resp_fault=1, resp_ppn=0; the entry still fills on a walk.
REQ-014 Victim: lowest-index invalid entry, else round-robin pointer, which then increments modulo ENTRIES.
REQ-015 Flush SHALL take effect at the accepting edge: all valid bits clear, or (asid mode) clear entries with G=0 and matching ASID; flush and request same cycle: flush wins.
REQ-016 ptw_done/ptw_fault outside WALK SHALL be ignored.
REQ-017 resp_* SHALL be 0 in every cycle resp_valid=0.

Reset
REQ-018 rst SHALL force state IDLE, all valid bits 0, round-robin pointer 0, resp_valid/resp_fault/resp_hit/resp_ppn 0, ptw_request 0; entry tag/data need no reset.
REQ-019 Reset during WALK SHALL drop ptw_request the same cycle; no response issues for the aborted request.

Structure
REQ-020 Package tlb_pkg SHALL hold state encodings, access codes, and flag bit positions (R=0,W=1,X=2,U=3).
REQ-021 Victim selection SHALL be sub-module tlb_victim_sel (valid vector + pointer in, index out, pointer register inside).

Verification
REQ-022 Cold miss load vpn 0x12345 asid 3, walker returns ppn 0xABCDE flags 0011 -> ptw_request until done, resp ppn 0xABCDE, hit=0, fault=0.
REQ-023 Repeat same request -> resp 2 cycles after accept, hit=1, ptw_request never asserted.
REQ-024 Store to entry with flags 0001 -> resp_fault=1, resp_ppn=0; user fetch on U=0 page -> fault.
REQ-025 Fill 8 entries, then 9th miss -> entry 0 replaced; next victim entry 1.
REQ-026 Fill asid 3 non-global and asid 5 global, flush_asid_en=1 asid 3 -> asid-3 lookup misses, global still hits; flush all -> everything misses.
REQ-027 rst asserted in WALK -> ptw_request low immediately, no resp_valid; later ptw_done ignored.
